wrn_cpu_iram_loader: RTL and testbench

Hardware end of the CPU firmware-upload CSR path: takes the per-word upload/readback strobes generated by the host-side CSR block (`core_sel`, `uaddr`, `udata`, `udata_load`) and turns them into write/read cycles on the instruction RAM of the selected CPU core. It sits between the CPU CSR register bank and the IRAM ports of the `g_num_cpus` cores. It enforces range checks and the rule that a core must be held in reset during upload, and returns readback data to the CSR bank.

---
 rtl/wrn_cpu_iram_loader_if.sv | 29 ++
 rtl/wrn_cpu_iram_loader.sv | 194 +++++++++++++++++++
 tb/tb_wrn_cpu_iram_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/wrn_cpu_iram_loader_if.sv
// rtl/wrn_cpu_iram_loader_if.sv - shared IRAM port bundle between the loader and the per-core instruction RAMs
interface wrn_cpu_iram_loader_if #(
    parameter int g_num_cpus  = 2,
    parameter int g_iram_size = 16384
);
    localparam int AW = $clog2(g_iram_size);

    logic [AW-1:0]            iram_addr_o;
    logic [31:0]              iram_data_o;
    logic [g_num_cpus-1:0]    iram_we_o;
    logic [g_num_cpus-1:0]    iram_rd_o;
    logic [32*g_num_cpus-1:0] iram_q_i;

    modport master (
        output iram_addr_o,
        output iram_data_o,
        output iram_we_o,
        output iram_rd_o,
        input  iram_q_i
    );

    modport slave (
        input  iram_addr_o,
        input  iram_data_o,
        input  iram_we_o,
        input  iram_rd_o,
        output iram_q_i
    );
endinterface

// File: rtl/wrn_cpu_iram_loader.sv
// rtl/wrn_cpu_iram_loader.sv - turns CSR upload/readback strobes into IRAM write/read cycles per CPU core
module wrn_cpu_iram_loader #(
    parameter int g_num_cpus  = 2,
    parameter int g_iram_size = 16384
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_n_i,
    input  logic [3:0]            core_sel_i,
    input  logic [31:0]           uaddr_i,
    input  logic [31:0]           udata_i,
    input  logic                  udata_load_i,
    input  logic                  uaddr_load_i,
    input  logic [g_num_cpus-1:0] cpu_reset_i,
    input  logic                  err_clr_i,
    output logic [31:0]           udata_o,
    output logic                  udata_valid_o,
    output logic                  busy_o,
    output logic [2:0]            err_o,
    wrn_cpu_iram_loader_if.master iram
);
    localparam int AW = $clog2(g_iram_size);
    localparam int CW = (g_num_cpus > 1) ? $clog2(g_num_cpus) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  slot_valid_q, slot_valid_d;
    logic                  slot_rd_q, slot_rd_d;
    logic [3:0]            slot_core_q, slot_core_d;
    logic [31:0]           slot_addr_q, slot_addr_d;
    logic [31:0]           slot_data_q, slot_data_d;
    logic [CW-1:0]         cur_core_q, cur_core_d;
    logic [AW-1:0]         iram_addr_q, iram_addr_d;
    logic [31:0]           iram_data_q, iram_data_d;
    logic [g_num_cpus-1:0] iram_we_q, iram_we_d;
    logic [g_num_cpus-1:0] iram_rd_q, iram_rd_d;
    logic [31:0]           udata_q, udata_d;
    logic                  udata_valid_q, udata_valid_d;
    logic [2:0]            err_q, err_d;

    logic                  req_rd;
    logic [3:0]            req_core;
    logic [31:0]           req_addr;
    logic [31:0]           req_data;
    logic                  issue, direct, core_ok, addr_ok, in_rst;
    logic [g_num_cpus-1:0] onehot;
    logic [31:0]           q_sel;

    always_comb begin
        state_d       = state_q;
        slot_valid_d  = slot_valid_q;
        slot_rd_d     = slot_rd_q;
        slot_core_d   = slot_core_q;
        slot_addr_d   = slot_addr_q;
        slot_data_d   = slot_data_q;
        cur_core_d    = cur_core_q;
        iram_addr_d   = iram_addr_q;
        iram_data_d   = iram_data_q;
        iram_we_d     = '0;
        iram_rd_d     = '0;
        udata_d       = udata_q;
        udata_valid_d = 1'b0;
        err_d         = err_clr_i ? 3'b000 : err_q;

        // The pending slot always wins over strobes arriving in the same cycle
        if (slot_valid_q) begin
            req_rd   = slot_rd_q;
            req_core = slot_core_q;
            req_addr = slot_addr_q;
            req_data = slot_data_q;
        end else begin
            req_rd   = !udata_load_i;
            req_core = core_sel_i;
            req_addr = uaddr_i;
            req_data = udata_i;
        end

        issue   = (state_q == ST_IDLE) && (slot_valid_q || udata_load_i || uaddr_load_i);
        direct  = (state_q == ST_IDLE) && !slot_valid_q;
        core_ok = {28'd0, req_core} < 32'(g_num_cpus);
        addr_ok = (req_addr >> AW) == 32'd0;

        in_rst = 1'b0;
        onehot = '0;
        q_sel  = 32'd0;
        for (int k = 0; k < g_num_cpus; k++) begin
            onehot[k] = (req_core == 4'(k));
            if (req_core == 4'(k)) in_rst = cpu_reset_i[k];
            if (cur_core_q == CW'(k)) q_sel = iram.iram_q_i[32*k +: 32];
        end

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    slot_valid_d = 1'b0;
                    if (!core_ok || !addr_ok) begin
                        err_d[0] = 1'b1;
                    end else if (!in_rst) begin
                        err_d[1] = 1'b1;
                    end else begin
                        cur_core_d  = req_core[CW-1:0];
                        iram_addr_d = req_addr[AW-1:0];
                        if (req_rd) begin
                            state_d   = ST_READ;
                            iram_rd_d = onehot;
                        end else begin
                            state_d     = ST_WRITE;
                            iram_we_d   = onehot;
                            iram_data_d = req_data;
                        end
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT: begin
                udata_d       = q_sel;
                udata_valid_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase

        // Strobes that cannot issue this cycle park in the slot; a write+read pair parks the read
        if (direct) begin
            if (udata_load_i && uaddr_load_i) begin
                slot_valid_d = 1'b1;
                slot_rd_d    = 1'b1;
                slot_core_d  = core_sel_i;
                slot_addr_d  = uaddr_i;
                slot_data_d  = udata_i;
            end
        end else if (udata_load_i || uaddr_load_i) begin
            if (slot_valid_q) begin
                err_d[2] = 1'b1;
            end else begin
                slot_valid_d = 1'b1;
                slot_rd_d    = !udata_load_i;
                slot_core_d  = core_sel_i;
                slot_addr_d  = uaddr_i;
                slot_data_d  = udata_i;
                if (udata_load_i && uaddr_load_i) err_d[2] = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            slot_valid_q  <= 1'b0;
            slot_rd_q     <= 1'b0;
            slot_core_q   <= 4'd0;
            slot_addr_q   <= 32'd0;
            slot_data_q   <= 32'd0;
            cur_core_q    <= '0;
            iram_addr_q   <= '0;
            iram_data_q   <= 32'd0;
            iram_we_q     <= '0;
            iram_rd_q     <= '0;
            udata_q       <= 32'd0;
            udata_valid_q <= 1'b0;
            err_q         <= 3'b000;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            slot_valid_q  <= slot_valid_d;
            slot_rd_q     <= slot_rd_d;
            slot_core_q   <= slot_core_d;
            slot_addr_q   <= slot_addr_d;
            slot_data_q   <= slot_data_d;
            cur_core_q    <= cur_core_d;
            iram_addr_q   <= iram_addr_d;
            iram_data_q   <= iram_data_d;
            iram_we_q     <= iram_we_d;
            iram_rd_q     <= iram_rd_d;
            udata_q       <= udata_d;
            udata_valid_q <= udata_valid_d;
            err_q         <= err_d;
        end
    end

    assign udata_o          = udata_q;
    assign udata_valid_o    = udata_valid_q;
    assign busy_o           = busy_q;
    assign err_o            = err_q;
    assign iram.iram_addr_o = iram_addr_q;
    assign iram.iram_data_o = iram_data_q;
    assign iram.iram_we_o   = iram_we_q;
    assign iram.iram_rd_o   = iram_rd_q;
endmodule

// File: tb/tb_wrn_cpu_iram_loader.sv
// tb/tb_wrn_cpu_iram_loader.sv - directed-vector bench for the IRAM loader with a two-core RAM model
module tb_wrn_cpu_iram_loader;
    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [3:0]  core_sel;
    logic [31:0] uaddr;
    logic [31:0] udata;
    logic        udata_load;
    logic        uaddr_load;
    logic [1:0]  cpu_reset;
    logic        err_clr;
    logic [31:0] udata_out;
    logic        udata_valid;
    logic        busy;
    logic [2:0]  err;

    int vectors = 0;
    int miscompares = 0;

    wrn_cpu_iram_loader_if #(.g_num_cpus(2), .g_iram_size(16384)) iram_if ();

    wrn_cpu_iram_loader #(.g_num_cpus(2), .g_iram_size(16384)) dut (
        .clk_sys_i     (clk_sys),
        .rst_n_i       (rst_n),
        .core_sel_i    (core_sel),
        .uaddr_i       (uaddr),
        .udata_i       (udata),
        .udata_load_i  (udata_load),
        .uaddr_load_i  (uaddr_load),
        .cpu_reset_i   (cpu_reset),
        .err_clr_i     (err_clr),
        .udata_o       (udata_out),
        .udata_valid_o (udata_valid),
        .busy_o        (busy),
        .err_o         (err),
        .iram          (iram_if.master)
    );

    always #5 clk_sys = ~clk_sys;

    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];

    always @(posedge clk_sys) begin
        if (iram_if.iram_we_o[0]) mem0[iram_if.iram_addr_o[7:0]] <= iram_if.iram_data_o;
        if (iram_if.iram_we_o[1]) mem1[iram_if.iram_addr_o[7:0]] <= iram_if.iram_data_o;
        if (iram_if.iram_rd_o[0]) iram_if.iram_q_i[31:0]  <= mem0[iram_if.iram_addr_o[7:0]];
        if (iram_if.iram_rd_o[1]) iram_if.iram_q_i[63:32] <= mem1[iram_if.iram_addr_o[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs();
        udata_load = 1'b0;
        uaddr_load = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic set_req(input logic wr, input logic rd, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] d);
        udata_load = wr;
        uaddr_load = rd;
        core_sel   = c;
        uaddr      = a;
        udata      = d;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        idle_inputs();
        check("err_clr", {29'd0, err}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_reset = 2'b01;
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        idle_inputs();
        step();
        step();
        check("rst_udata", udata_out, 32'd0);
        check("rst_valid", {31'd0, udata_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {29'd0, err}, 32'd0);
        check("rst_we", {30'd0, iram_if.iram_we_o}, 32'd0);
        check("rst_rd", {30'd0, iram_if.iram_rd_o}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single write to core 0
        set_req(1'b1, 1'b0, 4'd0, 32'h10, 32'hDEADBEEF);
        step();
        idle_inputs();
        check("wr_we", {30'd0, iram_if.iram_we_o}, 32'h1);
        check("wr_addr", {18'd0, iram_if.iram_addr_o}, 32'h10);
        check("wr_data", iram_if.iram_data_o, 32'hDEADBEEF);
        check("wr_busy", {31'd0, busy}, 32'd1);
        check("wr_err", {29'd0, err}, 32'd0);
        step();
        check("wr_we_off", {30'd0, iram_if.iram_we_o}, 32'd0);
        check("wr_busy_off", {31'd0, busy}, 32'd0);

        // Readback from core 0
        set_req(1'b0, 1'b1, 4'd0, 32'h10, 32'd0);
        step();
        idle_inputs();
        check("rd_rd", {30'd0, iram_if.iram_rd_o}, 32'h1);
        check("rd_busy1", {31'd0, busy}, 32'd1);
        step();
        check("rd_rd_off", {30'd0, iram_if.iram_rd_o}, 32'd0);
        check("rd_busy2", {31'd0, busy}, 32'd1);
        check("rd_valid_early", {31'd0, udata_valid}, 32'd0);
        step();
        check("rd_udata", udata_out, 32'hDEADBEEF);
        check("rd_valid", {31'd0, udata_valid}, 32'd1);
        check("rd_busy3", {31'd0, busy}, 32'd0);
        step();
        check("rd_valid_pulse", {31'd0, udata_valid}, 32'd0);
        check("rd_udata_hold", udata_out, 32'hDEADBEEF);

        // Range and reset-state rejections
        set_req(1'b1, 1'b0, 4'd0, 32'h4000, 32'h1);
        step();
        idle_inputs();
        check("range_we", {30'd0, iram_if.iram_we_o}, 32'd0);
        check("range_err", {29'd0, err}, 32'b001);
        check("range_busy", {31'd0, busy}, 32'd0);
        clear_err();
        set_req(1'b1, 1'b0, 4'd2, 32'h1, 32'h1);
        step();
        idle_inputs();
        check("core_err", {29'd0, err}, 32'b001);
        clear_err();
        set_req(1'b1, 1'b0, 4'd1, 32'h1, 32'h1);
        step();
        idle_inputs();
        check("nrst_we", {30'd0, iram_if.iram_we_o}, 32'd0);
        check("nrst_err", {29'd0, err}, 32'b010);
        clear_err();
        set_req(1'b1, 1'b0, 4'd0, 32'h8000_0000, 32'h1);
        err_clr = 1'b1;
        step();
        idle_inputs();
        check("clr_vs_event", {29'd0, err}, 32'b001);
        clear_err();

        // Core 1 path: one-hot enable and read-data select
        cpu_reset = 2'b11;
        set_req(1'b1, 1'b0, 4'd1, 32'h5, 32'hA5A50001);
        step();
        idle_inputs();
        check("c1_we", {30'd0, iram_if.iram_we_o}, 32'h2);
        step();
        set_req(1'b0, 1'b1, 4'd1, 32'h5, 32'd0);
        step();
        idle_inputs();
        check("c1_rd", {30'd0, iram_if.iram_rd_o}, 32'h2);
        step();
        step();
        check("c1_udata", udata_out, 32'hA5A50001);
        check("c1_valid", {31'd0, udata_valid}, 32'd1);
        cpu_reset = 2'b01;

        // Simultaneous write+read: read-after-write through the slot
        set_req(1'b1, 1'b1, 4'd0, 32'h20, 32'h12345678);
        step();
        idle_inputs();
        check("wr_rd_we", {30'd0, iram_if.iram_we_o}, 32'h1);
        check("wr_rd_rd1", {30'd0, iram_if.iram_rd_o}, 32'd0);
        step();
        check("wr_rd_rd2", {30'd0, iram_if.iram_rd_o}, 32'd0);
        step();
        check("wr_rd_rd3", {30'd0, iram_if.iram_rd_o}, 32'h1);
        check("wr_rd_addr", {18'd0, iram_if.iram_addr_o}, 32'h20);
        step();
        check("wr_rd_valid4", {31'd0, udata_valid}, 32'd0);
        step();
        check("wr_rd_udata", udata_out, 32'h12345678);
        check("wr_rd_valid5", {31'd0, udata_valid}, 32'd1);
        check("wr_rd_err", {29'd0, err}, 32'd0);

        // Three back-to-back writes: third overflows
        set_req(1'b1, 1'b0, 4'd0, 32'h30, 32'h30);
        step();
        check("b2b_we1", {30'd0, iram_if.iram_we_o}, 32'h1);
        check("b2b_addr1", {18'd0, iram_if.iram_addr_o}, 32'h30);
        set_req(1'b1, 1'b0, 4'd0, 32'h31, 32'h31);
        step();
        check("b2b_we2_off", {30'd0, iram_if.iram_we_o}, 32'd0);
        set_req(1'b1, 1'b0, 4'd0, 32'h32, 32'h32);
        step();
        idle_inputs();
        check("b2b_we3", {30'd0, iram_if.iram_we_o}, 32'h1);
        check("b2b_addr3", {18'd0, iram_if.iram_addr_o}, 32'h31);
        check("b2b_data3", iram_if.iram_data_o, 32'h31);
        check("b2b_err", {29'd0, err}, 32'b100);
        step();
        check("b2b_we4_off", {30'd0, iram_if.iram_we_o}, 32'd0);
        check("b2b_busy4", {31'd0, busy}, 32'd0);
        clear_err();

        // Reset in WAIT with a write parked in the slot
        set_req(1'b0, 1'b1, 4'd0, 32'h10, 32'd0);
        step();
        set_req(1'b1, 1'b0, 4'd0, 32'h40, 32'h40);
        step();
        idle_inputs();
        check("rst_wait_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_udata", udata_out, 32'd0);
        check("arst_valid", {31'd0, udata_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_err", {29'd0, err}, 32'd0);
        check("arst_we_rd", {28'd0, iram_if.iram_we_o, iram_if.iram_rd_o}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_quiet", {28'd0, udata_valid, busy, iram_if.iram_we_o[0], iram_if.iram_rd_o[0]}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
